// File: rtl/fp16_exp_combine_if.sv
// Operand/result channel between the partial-exp LUT stage and the FP16 combiner.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the producer holds its payload until then.
interface fp16_exp_combine_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      partial_exp1;
  logic [15:0]      partial_exp2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      exp_out;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, partial_exp1, partial_exp2, in_tag, out_ready,
    input  in_ready, out_valid, exp_out, out_tag, out_flags
  );

  modport slave (
    input  in_valid, partial_exp1, partial_exp2, in_tag, out_ready,
    output in_ready, out_valid, exp_out, out_tag, out_flags
  );
endinterface

// File: rtl/fp16_exp_combine.sv
// 3-stage FP16 multiplier forming exp(x) = partial_exp1 * partial_exp2.
// Stages: unpack/multiply, normalize/round-to-nearest-even, pack. Whole pipe freezes on output stall.
module fp16_exp_combine #(
  parameter int TAG_W = 8,
  parameter int FTZ   = 1
) (
  input logic               clk,
  input logic               rst,
  fp16_exp_combine_if.slave bus
);

  generate
    if (FTZ != 1) begin : g_ftz_check
      $error("fp16_exp_combine: only FTZ=1 is supported");
    end
  endgenerate

  logic stall;

  logic             s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [21:0]      s1_prod_q;
  logic signed [6:0] s1_exp_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic [9:0]       s2_frac_q;
  logic signed [6:0] s2_exp_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             out_valid_q;
  logic [15:0]      exp_out_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [2:0]       out_flags_q;

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Stage 1: classify operands, multiply mantissas, sum exponents.
  logic [4:0]  ea, eb;
  logic [9:0]  ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        s1_nan_d, s1_inf_d, s1_zero_d;
  logic [21:0] s1_prod_d;
  logic signed [6:0] s1_exp_d;

  assign ea     = bus.partial_exp1[14:10];
  assign eb     = bus.partial_exp2[14:10];
  assign ma     = bus.partial_exp1[9:0];
  assign mb     = bus.partial_exp2[9:0];
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'd31) && (ma == 10'd0);
  assign b_inf  = (eb == 5'd31) && (mb == 10'd0);
  assign a_nan  = (ea == 5'd31) && (ma != 10'd0);
  assign b_nan  = (eb == 5'd31) && (mb != 10'd0);

  assign s1_nan_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign s1_inf_d  = a_inf || b_inf;
  assign s1_zero_d = a_zero || b_zero;
  assign s1_prod_d = {11'd0, 1'b1, ma} * {11'd0, 1'b1, mb};
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;

  // Stage 2: normalize to 1.f, then round with guard and sticky.
  logic [9:0]  frac_t;
  logic        guard, sticky, round_up;
  logic [10:0] frac_r;
  logic signed [6:0] exp_n, s2_exp_d;

  always_comb begin
    if (s1_prod_q[21]) begin
      frac_t = s1_prod_q[20:11];
      guard  = s1_prod_q[10];
      sticky = |s1_prod_q[9:0];
      exp_n  = s1_exp_q + 7'sd1;
    end else begin
      frac_t = s1_prod_q[19:10];
      guard  = s1_prod_q[9];
      sticky = |s1_prod_q[8:0];
      exp_n  = s1_exp_q;
    end
  end

  assign round_up = guard && (sticky || frac_t[0]);
  assign frac_r   = {1'b0, frac_t} + {10'd0, round_up};
  // A carry out of the fraction leaves 10.000..., i.e. fraction zero with exponent bumped.
  assign s2_exp_d = exp_n + $signed({6'd0, frac_r[10]});

  // Stage 3: resolve specials in priority order and pack.
  logic [15:0] exp_out_d;
  logic [2:0]  out_flags_d;

  always_comb begin
    exp_out_d   = {s2_sign_q, s2_exp_q[4:0], s2_frac_q};
    out_flags_d = 3'b000;
    if (s2_nan_q) begin
      exp_out_d   = 16'h7E00;
      out_flags_d = 3'b100;
    end else if (s2_inf_q) begin
      exp_out_d = {s2_sign_q, 15'h7C00};
    end else if (s2_zero_q) begin
      exp_out_d = {s2_sign_q, 15'h0000};
    end else if (s2_exp_q >= 7'sd31) begin
      exp_out_d   = {s2_sign_q, 15'h7C00};
      out_flags_d = 3'b010;
    end else if (s2_exp_q <= 7'sd0) begin
      exp_out_d   = {s2_sign_q, 15'h0000};
      out_flags_d = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_prod_q   <= '0;
      s1_exp_q    <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_frac_q   <= '0;
      s2_exp_q    <= '0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      exp_out_q   <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else if (!stall) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_q   <= bus.partial_exp1[15] ^ bus.partial_exp2[15];
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      s1_zero_q   <= s1_zero_d;
      s1_prod_q   <= s1_prod_d;
      s1_exp_q    <= s1_exp_d;
      s1_tag_q    <= bus.in_tag;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_nan_q    <= s1_nan_q;
      s2_inf_q    <= s1_inf_q;
      s2_zero_q   <= s1_zero_q;
      s2_frac_q   <= frac_r[9:0];
      s2_exp_q    <= s2_exp_d;
      s2_tag_q    <= s1_tag_q;
      out_valid_q <= s2_valid_q;
      exp_out_q   <= exp_out_d;
      out_tag_q   <= s2_tag_q;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.exp_out   = exp_out_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp16_exp_combine.sv
// Directed and streaming bench for fp16_exp_combine with an independent integer reference model.
module tb_fp16_exp_combine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  logic [26:0] exp_q[$];  // {tag, flags, result}

  always #5 clk = ~clk;

  fp16_exp_combine_if #(.TAG_W(8)) bus ();

  fp16_exp_combine #(.TAG_W(8), .FTZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, then round-half-even by remainder comparison.
  function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, sh;
    longint m, q, rem, half;
    logic s;
    logic [4:0] e5;
    logic [9:0] f10;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = int'(a[9:0]);
    mb = int'(b[9:0]);
    if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0) ||
        (ea == 31 && eb == 0) || (eb == 31 && ea == 0))
      return {3'b100, 16'h7E00};
    if (ea == 31 || eb == 31) return {3'b000, s, 15'h7C00};
    if (ea == 0 || eb == 0) return {3'b000, s, 15'h0000};
    m  = longint'(1024 + ma) * longint'(1024 + mb);
    e  = ea + eb - 15;
    sh = (m >= 64'd2097152) ? 11 : 10;
    if (sh == 11) e++;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {3'b010, s, 15'h7C00};
    if (e <= 0) return {3'b001, s, 15'h0000};
    e5  = e[4:0];
    f10 = q[9:0];
    return {3'b000, s, e5, f10};
  endfunction

  function automatic logic [15:0] rand_normal();
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    s = 1'($urandom_range(0, 1));
    e = 5'($urandom_range(8, 22));
    m = 10'($urandom_range(0, 1023));
    return {s, e, m};
  endfunction

  // Single operation with free output: checks accept, latency 3, result, tag, flags.
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] tag, input logic [15:0] er, input logic [2:0] ef);
    int cyc;
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.partial_exp1 = a;
    bus.partial_exp2 = b;
    bus.in_tag       = tag;
    bus.out_ready    = 1'b1;
    #1 chk({name, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd3);
    chk({name, "_result"}, 32'(bus.exp_out), 32'(er));
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    chk({name, "_flags"}, 32'(bus.out_flags), 32'(ef));
  endtask

  // One clock of driving plus scoreboard bookkeeping for both handshakes.
  task automatic tick(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] tg, input logic ordy, output logic acc);
    logic [26:0] e;
    @(negedge clk);
    bus.in_valid     = iv;
    bus.partial_exp1 = a;
    bus.partial_exp2 = b;
    bus.in_tag       = tg;
    bus.out_ready    = ordy;
    #1;
    if (bus.out_valid && ordy) begin
      n_out++;
      chk("unexpected_output", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_result", {5'd0, bus.out_tag, bus.out_flags, bus.exp_out}, {5'd0, e});
      end
    end
    acc = iv && bus.in_ready;
    if (acc) exp_q.push_back({tg, ref_mul(a, b)});
  endtask

  initial begin
    logic acc;
    int   next_tag, sent, cyc, out_start;

    bus.in_valid     = 1'b0;
    bus.partial_exp1 = '0;
    bus.partial_exp2 = '0;
    bus.in_tag       = '0;
    bus.out_ready    = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_exp_out", 32'(bus.exp_out), 32'h0000);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    directed("one_x_one", 16'h3C00, 16'h3C00, 8'h11, 16'h3C00, 3'b000);
    directed("two_x_1p5", 16'h4000, 16'h3E00, 8'h12, 16'h4200, 3'b000);
    directed("round_down", 16'h3C01, 16'h3C01, 8'h13, 16'h3C02, 3'b000);
    directed("round_tie", 16'h3C01, 16'h3E00, 8'h14, 16'h3E02, 3'b000);
    directed("neg_sign", 16'hBC00, 16'h4000, 8'h15, 16'hC000, 3'b000);
    directed("overflow", 16'h7BFF, 16'h4000, 8'h16, 16'h7C00, 3'b010);
    directed("inf_pass", 16'h7C00, 16'h3C00, 8'h17, 16'h7C00, 3'b000);
    directed("zero_x_inf", 16'h0000, 16'h7C00, 8'h18, 16'h7E00, 3'b100);
    directed("nan_in", 16'hFE00, 16'h3C00, 8'h19, 16'h7E00, 3'b100);
    directed("underflow", 16'h0400, 16'h3800, 8'h1A, 16'h0000, 3'b001);
    directed("ftz_input", 16'h0001, 16'h3C00, 8'h1B, 16'h0000, 3'b000);

    // Backpressure: 1.0 * (1.0 + tag ulp) returns the second operand exactly.
    tick(1'b0, 16'h0, 16'h0, 8'h0, 1'b1, acc);
    next_tag = 1;
    repeat (6) begin
      tick(1'b1, 16'h3C00, 16'h3C00 | 16'(next_tag), 8'(next_tag), 1'b0, acc);
      if (acc) next_tag++;
    end
    chk("bp_accepted", 32'(next_tag - 1), 32'd3);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (2) begin
      tick(1'b1, 16'h3C00, 16'h3C00 | 16'(next_tag), 8'(next_tag), 1'b0, acc);
      if (acc) next_tag++;
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_result", 32'(bus.exp_out), 32'h3C01);
      chk("bp_hold_tag", 32'(bus.out_tag), 32'd1);
    end
    out_start = n_out;
    cyc = 0;
    while ((exp_q.size() != 0 || next_tag <= 4) && cyc < 20) begin
      tick(next_tag <= 4, 16'h3C00, 16'h3C00 | 16'(next_tag), 8'(next_tag), 1'b1, acc);
      if (acc) next_tag++;
      cyc++;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_out_count", 32'(n_out - out_start), 32'd4);

    // Streaming with random gaps on both sides.
    sent = 0;
    cyc  = 0;
    out_start = n_out;
    while ((sent < 100 || exp_q.size() != 0) && cyc < 3000) begin
      tick((sent < 100) && ($urandom_range(0, 3) != 0), rand_normal(), rand_normal(),
           8'(sent), $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("stream_sent", 32'(sent), 32'd100);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_out_count", 32'(n_out - out_start), 32'd100);

    // Reset with two operations in flight.
    tick(1'b1, 16'h3C00, 16'h4000, 8'h21, 1'b1, acc);
    tick(1'b1, 16'h3C00, 16'h4000, 8'h22, 1'b1, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) begin
      @(negedge clk);
      #1 chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end
    directed("post_rst_op", 16'h3C00, 16'h4000, 8'h33, 16'h4000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_exp_combine.md
Name: fp16_exp_combine

Overview:
- Consumer end of the FP16 partial-exponent interface. Takes the two partial factors produced by the FP16 partial-exp stage and forms exp(x) = partial_exp1 × partial_exp2 as one FP16 result.
- 3-stage pipelined FP16 multiplier with valid/ready handshake and a sideband tag.
- Sits between the partial-exp LUT stage and the softmax/activation datapath.

Parameters:
TAG_W, 8, width of opaque sideband tag carried alongside each operation
FTZ, 1, 1 = flush subnormal inputs/outputs to signed zero (only supported value; 0 is illegal and must trigger an elaboration error)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
partial_exp1  input  16  FP16 factor (fractional-part exp)
partial_exp2  input  16  FP16 factor (integer/low-frac exp)
in_tag  input  TAG_W  sideband, returned unchanged with result
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
exp_out  output  16  FP16 product
out_tag  output  TAG_W  tag of this result
out_flags  output  3  {nan, overflow, underflow} for this result

Behaviour:
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - On stall all three stages hold, including bubbles.
  - Bubbles do not collapse. Max occupancy is 3.
- Latency: exactly 3 cycles from accept to out_valid when not stalled. Throughput 1/cycle.
- Reset:
  - All stage valid bits clear; out_valid = 0; exp_out = 0x0000; out_tag = 0; out_flags = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight operations; none emerge afterwards.
- Stage 1 (unpack):
  - sign = s1 ^ s2.
  - Exponent 0 is treated as zero (FTZ).
  - Mantissas get the hidden bit → 11b each; 22b unsigned mantissa product.
  - Exponent sum e = e1 + e2 − 15, held as signed 7b.
  - Special-case class computed here and carried down the pipe.
- Stage 2 (normalize/round):
  - If product bit 21 is set: shift right 1 and e += 1.
  - Keep 10 fraction bits plus guard bit and sticky (OR of the rest).
  - Round to nearest, ties to even.
  - Rounding carry-out into bit 11 renormalizes (e += 1).
- Stage 3: pack into the output register; drives exp_out, out_tag, out_flags.
- Special cases, in priority order:
  1. Any NaN input, or inf×0 → 0x7E00 (canonical NaN, sign ignored); nan = 1.
  2. Any inf input → sign|0x7C00.
  3. Any zero/subnormal input → sign|0x0000.
  4. Final e ≥ 31 → sign|0x7C00; overflow = 1.
  5. Final e ≤ 0 → sign|0x0000; underflow = 1. No subnormal outputs are produced.
- Flags are valid only with out_valid. They are zero for special-case passthroughs (2) and (3).
- exp_out, out_tag and out_flags hold stable while out_valid && !out_ready.

Test Plan:
- Basic products: 0x3C00×0x3C00 → 0x3C00; 0x4000×0x3E00 → 0x4200. Each appears exactly 3 cycles after accept; flags 0.
- Rounding:
  - 0x3C01×0x3C01 → 0x3C02 (below half, round down).
  - Tie case 0x3C01×0x3E00 → 0x3E02 (tie, round to even = up).
- Specials:
  - 0x7BFF×0x4000 → 0x7C00 with overflow = 1.
  - 0x7C00×0x3C00 → 0x7C00 with flags 0.
  - 0x0000×0x7C00 → 0x7E00 with nan = 1.
  - 0x0400×0x3800 → 0x0000 with underflow = 1.
  - 0x0001×0x3C00 → 0x0000 (FTZ input).
- Backpressure: hold out_ready = 0 and offer 4 back-to-back ops with tags 1..4.
  - Exactly 3 are accepted; in_ready drops once out_valid rises.
  - Result of tag 1 holds stable.
  - On releasing out_ready, results emerge in order with tags 1..4, no loss or duplication.
- Streaming: 100 random normal-range operand pairs with random out_ready. Results match the reference model bit-exactly, in order, with matching tags.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle. out_valid stays 0 for the next 5 cycles, and the next accepted op returns correctly at latency 3.
